// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler
//   Per-frame sequencer and VGA write-port arbiter. A free-running frame
//   counter produces frame_tick; each accepted tick runs erase -> update ->
//   pipe draw -> bird draw, and the single VGA write port is muxed to the
//   client owning the current draw phase.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   enable                   allow new frames to start
//   *_done                   draw client finished (pulse or level)
//   *_plot/_x/_y/_col        draw client write requests (erase, pipe, bird)
//   start_erase/pipe/bird    1-cycle start pulses to the draw clients
//   move_en                  1-cycle game-state update strobe
//   vga_plot/x/y/colour      muxed VGA write port
//   frame_tick               1-cycle pulse at the end of each frame period
//   busy, phase              sequencer status (phase: 0 WAIT .. 4 BIRD)
//   frame_drop               saturating count of ticks that arrived while busy
//   timeout_err              sticky, set when a draw phase timed out
//
// state    | meaning
// ---------+---------------------------------------------------
// S_WAIT   | idle, waiting for frame_tick with enable
// S_ERASE  | erase client owns VGA port, waiting for erase_done
// S_UPDATE | single cycle, move_en strobe
// S_PIPE   | pipe client owns VGA port, waiting for pipe_done
// S_BIRD   | bird client owns VGA port, waiting for bird_done
module frame_draw_scheduler #(
  parameter int FRAME_CYCLES   = 833334,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       erase_done,
  input  logic       pipe_done,
  input  logic       bird_done,
  input  logic       erase_plot,
  input  logic [7:0] erase_x,
  input  logic [6:0] erase_y,
  input  logic [2:0] erase_col,
  input  logic       pipe_plot,
  input  logic [7:0] pipe_x,
  input  logic [6:0] pipe_y,
  input  logic [2:0] pipe_col,
  input  logic       bird_plot,
  input  logic [7:0] bird_x,
  input  logic [6:0] bird_y,
  input  logic [2:0] bird_col,
  output logic       start_erase,
  output logic       start_pipe,
  output logic       start_bird,
  output logic       move_en,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       frame_tick,
  output logic       busy,
  output logic [2:0] phase,
  output logic [7:0] frame_drop,
  output logic       timeout_err
);

  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_PIPE   = 3'd3,
    S_BIRD   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          first_q, first_d;
  logic [7:0]    frame_drop_q, frame_drop_d;
  logic          timeout_err_q, timeout_err_d;

  logic tick;
  logic draw_phase;
  logic done_sel;
  logic done_ok;
  logic phase_end;

  always_comb begin
    tick        = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d = tick ? '0 : frame_cnt_q + FW'(1);

    done_sel = 1'b0;
    case (state_q)
      S_ERASE: done_sel = erase_done;
      S_PIPE:  done_sel = pipe_done;
      S_BIRD:  done_sel = bird_done;
      default: done_sel = 1'b0;
    endcase

    draw_phase = (state_q == S_ERASE) || (state_q == S_PIPE) || (state_q == S_BIRD);
    // done is ignored in the start cycle so a level left high by the client
    // from its previous job cannot end the phase immediately
    done_ok    = !first_q && done_sel;
    phase_end  = draw_phase && (done_ok || (tmo_cnt_q == TMO_LAST));

    state_d       = state_q;
    first_d       = 1'b0;
    tmo_cnt_d     = tmo_cnt_q + TW'(1);
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_WAIT: begin
        tmo_cnt_d = '0;
        if (tick && enable) begin
          state_d = S_ERASE;
          first_d = 1'b1;
        end
      end
      S_ERASE: if (phase_end) state_d = S_UPDATE;
      S_UPDATE: begin
        state_d   = S_PIPE;
        first_d   = 1'b1;
        tmo_cnt_d = '0;
      end
      S_PIPE: begin
        if (phase_end) begin
          state_d = S_BIRD;
          first_d = 1'b1;
        end
      end
      S_BIRD: if (phase_end) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase

    if (phase_end) begin
      tmo_cnt_d = '0;
      if (!done_ok) timeout_err_d = 1'b1;
    end

    // overrun: the tick is counted, never queued
    frame_drop_d = frame_drop_q;
    if (tick && (state_q != S_WAIT) && (frame_drop_q != 8'hFF))
      frame_drop_d = frame_drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT;
      frame_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      first_q       <= 1'b0;
      frame_drop_q  <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      first_q       <= first_d;
      frame_drop_q  <= frame_drop_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // strobes and the VGA port are held low while reset is asserted, even if
  // the state register still shows a draw phase in that cycle
  always_comb begin
    start_erase = !reset && (state_q == S_ERASE) && first_q;
    start_pipe  = !reset && (state_q == S_PIPE)  && first_q;
    start_bird  = !reset && (state_q == S_BIRD)  && first_q;
    move_en     = !reset && (state_q == S_UPDATE);
    frame_tick  = !reset && tick;

    vga_plot   = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    if (!reset) begin
      case (state_q)
        S_ERASE: begin
          vga_plot = erase_plot; vga_x = erase_x; vga_y = erase_y; vga_colour = erase_col;
        end
        S_PIPE: begin
          vga_plot = pipe_plot; vga_x = pipe_x; vga_y = pipe_y; vga_colour = pipe_col;
        end
        S_BIRD: begin
          vga_plot = bird_plot; vga_x = bird_x; vga_y = bird_y; vga_colour = bird_col;
        end
        default: ;
      endcase
    end

    busy        = (state_q != S_WAIT);
    phase       = state_q;
    frame_drop  = frame_drop_q;
    timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
`timescale 1ns/1ps
module tb_frame_draw_scheduler;
  localparam int FR   = 20;
  localparam int TMO  = 16;
  localparam int NMAX = 8192;
  localparam int KMAX = 512;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic       erase_done = 1'b0, pipe_done = 1'b0, bird_done = 1'b0;
  logic       erase_plot = 1'b0, pipe_plot = 1'b0, bird_plot = 1'b0;
  logic [7:0] erase_x = '0, pipe_x = '0, bird_x = '0;
  logic [6:0] erase_y = '0, pipe_y = '0, bird_y = '0;
  logic [2:0] erase_col = '0, pipe_col = '0, bird_col = '0;
  logic       start_erase, start_pipe, start_bird, move_en;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       frame_tick, busy, timeout_err;
  logic [2:0] phase;
  logic [7:0] frame_drop;

  always #5 clk = ~clk;

  frame_draw_scheduler #(.FRAME_CYCLES(FR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .erase_done(erase_done), .pipe_done(pipe_done), .bird_done(bird_done),
    .erase_plot(erase_plot), .erase_x(erase_x), .erase_y(erase_y), .erase_col(erase_col),
    .pipe_plot(pipe_plot), .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_col(pipe_col),
    .bird_plot(bird_plot), .bird_x(bird_x), .bird_y(bird_y), .bird_col(bird_col),
    .start_erase(start_erase), .start_pipe(start_pipe), .start_bird(start_bird),
    .move_en(move_en), .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .frame_tick(frame_tick), .busy(busy), .phase(phase),
    .frame_drop(frame_drop), .timeout_err(timeout_err)
  );

  int n_chk = 0, n_pass = 0;
  int exp_phase[NMAX];
  int exp_drop[NMAX];
  bit exp_err[NMAX];
  bit en_arr[NMAX];
  int e_d[KMAX], p_d[KMAX], b_d[KMAX];   // done delay after start; 0 = withheld
  bit e_e[KMAX], p_e[KMAX], b_e[KMAX];   // extra done pulse in the start cycle
  int exp_q[$];                          // expected pulses: kind*100000 + cycle
  int cur_c = 0;
  bit mon_on = 1'b0;

  task automatic check(string name, int c, longint got, longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, got, expv);
  endtask

  function automatic int dur(int d);
    if (d == 0 || d >= TMO) return TMO;
    return d + 1;
  endfunction

  function automatic bit timed_out(int d);
    return (d == 0 || d >= TMO);
  endfunction

  function automatic logic [18:0] exp_vga(int ph);
    case (ph)
      1: return {erase_plot, erase_x, erase_y, erase_col};
      3: return {pipe_plot, pipe_x, pipe_y, pipe_col};
      4: return {bird_plot, bird_x, bird_y, bird_col};
      default: return '0;
    endcase
  endfunction

  // Frame-level timeline: a frame started by the tick at cycle t occupies
  // erase [t+1, +De), update 1 cycle, pipe Dp, bird Db, then idle again.
  task automatic build_model(int n);
    int c, k, s, de, dp, db, errc, dcnt;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_phase[i] = 0;
    errc = NMAX + 1;
    c = 0;
    k = 0;
    while (c < n) begin
      if ((c % FR) == FR - 1 && en_arr[c]) begin
        s  = c + 1;
        de = dur(e_d[k]);
        dp = dur(p_d[k]);
        db = dur(b_d[k]);
        if (s < n)               exp_q.push_back(100000 + s);
        if (s + de < n)          exp_q.push_back(200000 + s + de);
        if (s + de + 1 < n)      exp_q.push_back(300000 + s + de + 1);
        if (s + de + 1 + dp < n) exp_q.push_back(400000 + s + de + 1 + dp);
        for (int i = s; i < s + de && i < n; i++) exp_phase[i] = 1;
        if (s + de < n) exp_phase[s + de] = 2;
        for (int i = s + de + 1; i < s + de + 1 + dp && i < n; i++) exp_phase[i] = 3;
        for (int i = s + de + 1 + dp; i < s + de + 1 + dp + db && i < n; i++) exp_phase[i] = 4;
        if (timed_out(b_d[k]) && s + de + 1 + dp + db < errc) errc = s + de + 1 + dp + db;
        if (timed_out(p_d[k]) && s + de + 1 + dp < errc) errc = s + de + 1 + dp;
        if (timed_out(e_d[k]) && s + de < errc) errc = s + de;
        c = s + de + 1 + dp + db;
        k++;
      end else begin
        c++;
      end
    end
    dcnt = 0;
    for (int i = 0; i < n; i++) begin
      exp_drop[i] = dcnt;
      exp_err[i]  = (i >= errc);
      if ((i % FR) == FR - 1 && exp_phase[i] != 0 && dcnt < 255) dcnt++;
    end
  endtask

  task automatic setup(int mode, int n);
    int seg;
    bit en;
    for (int k = 0; k < KMAX; k++) begin
      e_e[k] = 0; p_e[k] = 0; b_e[k] = 0;
      case (mode)
        1: begin
          e_d[k] = $urandom_range(1, 8); p_d[k] = $urandom_range(1, 8);
          b_d[k] = $urandom_range(1, 8); p_e[k] = 1;
        end
        3: begin e_d[k] = 0; p_d[k] = 0; b_d[k] = 0; end
        4: begin
          e_d[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 3);
          p_d[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 3);
          b_d[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 3);
          e_e[k] = 1'($urandom_range(0, 1));
          p_e[k] = 1'($urandom_range(0, 1));
          b_e[k] = 1'($urandom_range(0, 1));
        end
        default: begin e_d[k] = 5; p_d[k] = 5; b_d[k] = 5; end
      endcase
    end
    if (mode == 2) b_d[0] = 0;
    seg = 0;
    en  = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (mode == 4) begin
        if (seg == 0) begin
          en  = ($urandom_range(0, 3) != 0);
          seg = $urandom_range(1, 60);
        end
        seg--;
        en_arr[c] = en;
      end else if (mode == 5) begin
        en_arr[c] = (c < 30) || (c >= 150);
      end else begin
        en_arr[c] = 1'b1;
      end
    end
  endtask

  // Resets the DUT, then drives n cycles; clients answer start pulses with
  // done after the scheduled delay. Leaves the bench just after the n-th edge.
  task automatic run(int n);
    int ke, kp, kb, e_at, p_at, b_at;
    ke = 0; kp = 0; kb = 0; e_at = -1; p_at = -1; b_at = -1;
    mon_on = 1'b0;
    reset = 1'b1; enable = 1'b0;
    erase_done = 1'b0; pipe_done = 1'b0; bird_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < n; c++) begin
      cur_c = c;
      enable = en_arr[c];
      erase_done = (c == e_at);
      pipe_done  = (c == p_at);
      bird_done  = (c == b_at);
      if (start_erase) begin
        e_at = (e_d[ke % KMAX] > 0) ? c + e_d[ke % KMAX] : -1;
        if (e_e[ke % KMAX]) erase_done = 1'b1;
        ke++;
      end
      if (start_pipe) begin
        p_at = (p_d[kp % KMAX] > 0) ? c + p_d[kp % KMAX] : -1;
        if (p_e[kp % KMAX]) pipe_done = 1'b1;
        kp++;
      end
      if (start_bird) begin
        b_at = (b_d[kb % KMAX] > 0) ? c + b_d[kb % KMAX] : -1;
        if (b_e[kb % KMAX]) bird_done = 1'b1;
        kb++;
      end
      erase_plot = 1'($urandom_range(0, 1)); erase_x = 8'($urandom_range(0, 159));
      erase_y = 7'($urandom_range(0, 119)); erase_col = 3'($urandom_range(0, 7));
      pipe_plot = 1'($urandom_range(0, 1)); pipe_x = 8'($urandom_range(0, 159));
      pipe_y = 7'($urandom_range(0, 119)); pipe_col = 3'($urandom_range(0, 7));
      bird_plot = 1'($urandom_range(0, 1)); bird_x = 8'($urandom_range(0, 159));
      bird_y = 7'($urandom_range(0, 119)); bird_col = 3'($urandom_range(0, 7));
      mon_on = 1'b1;
      @(posedge clk);
      #1;
    end
    mon_on = 1'b0;
  endtask

  always @(negedge clk) begin
    int c, nst, kind, ev;
    if (mon_on) begin
      c = cur_c;
      check("phase", c, phase, exp_phase[c]);
      check("busy", c, busy, exp_phase[c] != 0);
      check("frame_tick", c, frame_tick, (c % FR) == FR - 1);
      check("frame_drop", c, frame_drop, exp_drop[c]);
      check("timeout_err", c, timeout_err, exp_err[c]);
      check("vga_port", c, {vga_plot, vga_x, vga_y, vga_colour}, exp_vga(exp_phase[c]));
      nst = int'(start_erase) + int'(move_en) + int'(start_pipe) + int'(start_bird);
      if (nst != 0) begin
        check("single_strobe", c, nst, 1);
        kind = start_erase ? 1 : move_en ? 2 : start_pipe ? 3 : 4;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", c, kind * 100000 + c, 0);
        end else begin
          ev = exp_q.pop_front();
          check("strobe", c, kind * 100000 + c, ev);
        end
      end
    end
  end

  task automatic scenario(int mode, int n);
    setup(mode, n);
    build_model(n);
    run(n);
    check("strobes_missing", n, exp_q.size(), 0);
  endtask

  initial begin
    int n, r;
    scenario(0, 300);   // basic walk, done after 5 cycles
    scenario(1, 600);   // done pulse in the pipe start cycle is ignored
    scenario(2, 400);   // bird timeout in first frame, sticky error
    scenario(5, 300);   // enable dropped during pipe phase
    scenario(4, 3000);  // randomized delays, timeouts and enable

    // every phase times out: overruns saturate, then reset mid-pipe
    n = 8000;
    setup(3, n);
    build_model(n);
    r = 0;
    for (int c = n - 1; c > 0; c--) begin
      if (exp_phase[c] == 3) begin r = c; break; end
    end
    while (exp_q.size() > 0 && (exp_q[$] % 100000) >= r) void'(exp_q.pop_back());
    run(r);
    check("strobes_missing", r, exp_q.size(), 0);
    reset = 1'b1;
    erase_plot = 1'b1; pipe_plot = 1'b1; bird_plot = 1'b1;
    @(negedge clk);
    check("drop_saturated", r, frame_drop, 255);
    check("reset_cycle_outputs", r,
          {start_erase, start_pipe, start_bird, move_en, frame_tick, vga_plot}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_phase", r + 1, phase, 0);
    check("post_reset_drop", r + 1, frame_drop, 0);
    check("post_reset_err", r + 1, timeout_err, 0);
    check("post_reset_strobes", r + 1,
          {start_erase, start_pipe, start_bird, move_en, vga_plot, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
